// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and default sizes for bus_rr_arbiter
package bus_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_NUM_SRC = 4;
  localparam int XFER_CNT_W = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search; req/ptr in, first requester at or after ptr (with wrap) as winner, any_req out
module rr_pick #(
  parameter int NUM_SRC = bus_pkg::DEFAULT_NUM_SRC,
  localparam int IDX_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);
  logic [IDX_W-1:0] k;
  always_comb begin
    winner = '0;
    k = '0;
    any_req = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      k = IDX_W'((int'(ptr) + i) % NUM_SRC);
      winner = req[k] ? k : winner;
    end
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin NUM_SRC->1 registered bus arbiter; in: clk, rst_n, src_req, src_data, bus_ready; out: src_ack, bus_valid, bus_data, bus_gnt_idx (+ xfer_cnt when BUS_XFER_CNT_EN is defined)
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  localparam int IDX_W = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ack,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [WIDTH-1:0]         bus_data,
  output logic [IDX_W-1:0]         bus_gnt_idx
`ifdef BUS_XFER_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0]    xfer_cnt
`endif
);
  state_t state;
  logic [IDX_W-1:0] rr_ptr, winner;
  logic any_req, capture;
  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req(src_req),
    .ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  assign capture = rst_n && any_req && (state == IDLE || bus_ready);
  assign src_ack = capture ? NUM_SRC'(1) << winner : '0;
  assign bus_valid = state == BUSY;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus_data <= '0;
      bus_gnt_idx <= '0;
      rr_ptr <= '0;
    end else if (capture) begin
      state <= BUSY;
      bus_data <= src_data[winner*WIDTH +: WIDTH];
      bus_gnt_idx <= winner;
      rr_ptr <= winner == IDX_W'(NUM_SRC - 1) ? '0 : winner + 1'b1;
    end else if (bus_ready) begin
      state <= IDLE;
    end
  end
`ifdef BUS_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt <= '0;
    else if (bus_valid && bus_ready) xfer_cnt <= xfer_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed self-checking bench for bus_rr_arbiter (WIDTH=4, NUM_SRC=4), xfer_cnt test under BUS_XFER_CNT_EN
module tb_bus_rr_arbiter;
  logic clk = 0;
  logic rst_n;
  logic [3:0] src_req;
  logic [15:0] src_data;
  logic [3:0] src_ack;
  logic bus_valid, bus_ready;
  logic [3:0] bus_data;
  logic [1:0] bus_gnt_idx;
  logic [3:0] d [4];
  int checks = 0, failures = 0;
`ifdef BUS_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif
  assign src_data = {d[3], d[2], d[1], d[0]};
  always #5 clk = ~clk;
  bus_rr_arbiter #(.WIDTH(4), .NUM_SRC(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_req(src_req),
    .src_data(src_data),
    .src_ack(src_ack),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_data(bus_data),
    .bus_gnt_idx(bus_gnt_idx)
`ifdef BUS_XFER_CNT_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_chk(input string tag, input logic v, input logic [3:0] dat, input logic [1:0] idx);
    check({tag, "_valid"}, 32'(bus_valid), 32'(v));
    check({tag, "_data"}, 32'(bus_data), 32'(dat));
    check({tag, "_idx"}, 32'(bus_gnt_idx), 32'(idx));
  endtask
  task automatic do_reset();
    rst_n = 0;
    src_req = '0;
    bus_ready = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask
  initial begin
    d[0] = 4'b0111;
    d[1] = 4'b1101;
    d[2] = 4'b0101;
    d[3] = 4'b0010;
    do_reset();
    bus_chk("reset", 0, 4'h0, 2'd0);
    check("reset_ack", 32'(src_ack), 0);
    // single source
    src_req = 4'b0010;
    bus_ready = 1;
    #1 check("single_ack", 32'(src_ack), 32'h2);
    tick();
    src_req = '0;
    #1 bus_chk("single", 1, 4'b1101, 2'd1);
    check("single_ack_after", 32'(src_ack), 0);
    tick();
    check("single_idle", 32'(bus_valid), 0);
    // round robin from rr_ptr=0
    do_reset();
    src_req = 4'b1110;
    bus_ready = 1;
    #1 check("rr_ack0", 32'(src_ack), 32'h2);
    tick();
    bus_chk("rr0", 1, 4'b1101, 2'd1);
    check("rr_ack1", 32'(src_ack), 32'h4);
    tick();
    bus_chk("rr1", 1, 4'b0101, 2'd2);
    check("rr_ack2", 32'(src_ack), 32'h8);
    tick();
    bus_chk("rr2", 1, 4'b0010, 2'd3);
    check("rr_ack3", 32'(src_ack), 32'h2);
    tick();
    bus_chk("rr3", 1, 4'b1101, 2'd1);
    // backpressure, rr_ptr=2
    src_req = 4'b1111;
    bus_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_ack", 32'(src_ack), 0);
      bus_chk("bp_hold", 1, 4'b1101, 2'd1);
      tick();
    end
    bus_ready = 1;
    #1 check("bp_release_ack", 32'(src_ack), 32'h4);
    tick();
    // wrap: rr_ptr=3, only src0 requesting
    src_req = 4'b0001;
    #1 bus_chk("bp_next", 1, 4'b0101, 2'd2);
    check("wrap_ack", 32'(src_ack), 32'h1);
    tick();
    src_req = '0;
    #1 bus_chk("wrap", 1, 4'b0111, 2'd0);
    tick();
    check("wrap_idle", 32'(bus_valid), 0);
    // withdrawal: rr_ptr=1, src1 grabbed while sink stalls
    src_req = 4'b0010;
    bus_ready = 0;
    #1 check("wd_ack1", 32'(src_ack), 32'h2);
    tick();
    src_req = 4'b0100;
    #1 check("wd_raise_ack", 32'(src_ack), 0);
    tick();
    src_req = 4'b0000;
    #1 check("wd_lower_ack", 32'(src_ack), 0);
    tick();
    bus_ready = 1;
    #1 check("wd_ready_ack", 32'(src_ack), 0);
    bus_chk("wd_hold", 1, 4'b1101, 2'd1);
    tick();
    check("wd_idle", 32'(bus_valid), 0);
    tick();
    check("ready_idle_ignored", 32'(bus_valid), 0);
    // async reset mid-BUSY
    src_req = 4'b0010;
    tick();
    src_req = '0;
    bus_ready = 0;
    #1 bus_chk("pre_rst", 1, 4'b1101, 2'd1);
    #1 rst_n = 0;
    #1 bus_chk("async_rst", 0, 4'h0, 2'd0);
    check("async_rst_ack", 32'(src_ack), 0);
    tick();
    rst_n = 1;
    tick();
`ifdef BUS_XFER_CNT_EN
    check("cnt_reset", 32'(xfer_cnt), 0);
    src_req = 4'b1111;
    bus_ready = 1;
    for (int i = 0; i < 65538; i++) tick();
    check("cnt_wrap", 32'(xfer_cnt), 1);
    src_req = '0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
